// File: rtl/tone_oscillator.sv
// Pitch-modulated square/pulse tone generator with a prescaled tick and a per-period strobe.
// Optional programmable duty cycle when TONE_OSC_DUTY_EN is defined (duty port added).
module tone_oscillator #(
  parameter int PERIOD_W = 12,
  parameter int PRESCALE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          vibrato_i,
  input  logic [1:0]          vib_shift,
`ifdef TONE_OSC_DUTY_EN
  input  logic [7:0]          duty,
`endif
  output logic                wave_o,
  output logic                cycle_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
  logic [PERIOD_W-1:0] cur_thr_q, cur_thr_d;
  logic                wave_q, wave_d;
  logic                cycle_q, cycle_d;

  logic                tick;
  logic [PERIOD_W:0]   vib_ext;
  logic [PERIOD_W:0]   p_sum;
  logic [PERIOD_W-1:0] p_eff;
  logic [PERIOD_W-1:0] thr_calc;

  // Effective period: base plus scaled vibrato, saturated at the counter width.
  always_comb begin
    vib_ext = (PERIOD_W+1)'(vibrato_i) << vib_shift;
    p_sum   = {1'b0, period} + vib_ext;
    if (period == '0) begin
      p_eff = '0;
    end else if (p_sum[PERIOD_W]) begin
      p_eff = '1;
    end else begin
      p_eff = p_sum[PERIOD_W-1:0];
    end
  end

`ifdef TONE_OSC_DUTY_EN
  logic [PERIOD_W+8:0] duty_prod;
  always_comb begin
    duty_prod = (PERIOD_W+9)'(p_eff) * (PERIOD_W+9)'({1'b0, duty} + 9'd1);
    thr_calc  = PERIOD_W'(duty_prod >> 8);
  end
`else
  logic [PERIOD_W:0] p_plus1;
  always_comb begin
    p_plus1  = {1'b0, p_eff} + (PERIOD_W+1)'(1);
    thr_calc = PERIOD_W'(p_plus1 >> 1);
  end
`endif

  assign tick = enable && (pre_cnt_q == PRE_LAST);

  always_comb begin
    pre_cnt_d    = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PRE_W'(1);
    phase_d      = phase_q;
    cur_period_d = cur_period_q;
    cur_thr_d    = cur_thr_q;
    cycle_d      = 1'b0;

    if (tick) begin
      if (cur_period_q == '0) begin
        // Idle: load only; the first phase starts now without a strobe.
        cur_period_d = p_eff;
        cur_thr_d    = thr_calc;
        phase_d      = '0;
      end else if (phase_q == cur_period_q - PERIOD_W'(1)) begin
        phase_d      = '0;
        cycle_d      = 1'b1;
        cur_period_d = p_eff;
        cur_thr_d    = thr_calc;
      end else begin
        phase_d = phase_q + PERIOD_W'(1);
      end
    end

    // Disable overrides any simultaneous tick.
    if (!enable) begin
      pre_cnt_d    = '0;
      phase_d      = '0;
      cur_period_d = '0;
      cur_thr_d    = '0;
      cycle_d      = 1'b0;
    end

    wave_d = (cur_period_d != '0) && (phase_d < cur_thr_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q    <= '0;
      phase_q      <= '0;
      cur_period_q <= '0;
      cur_thr_q    <= '0;
      wave_q       <= 1'b0;
      cycle_q      <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      phase_q      <= phase_d;
      cur_period_q <= cur_period_d;
      cur_thr_q    <= cur_thr_d;
      wave_q       <= wave_d;
      cycle_q      <= cycle_d;
    end
  end

  assign wave_o  = wave_q;
  assign cycle_o = cycle_q;

endmodule

// File: tb/tb_tone_oscillator.sv
// Scenario bench for tone_oscillator (PERIOD_W=12, PRESCALE=2): expected {wave_o,cycle_o}
// per clock is queued from the scenario's tick arithmetic and compared as the DUT runs.
module tb_tone_oscillator;

  localparam int PERIOD_W = 12;
  localparam int PRESCALE = 2;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          vibrato_i;
  logic [1:0]          vib_shift;
  logic [7:0]          duty;
  logic                wave_o;
  logic                cycle_o;

  logic [1:0] exp_q[$];
  logic [1:0] exp_v;
  int         n_vec;
  int         n_err;

  tone_oscillator #(.PERIOD_W(PERIOD_W), .PRESCALE(PRESCALE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .period    (period),
    .vibrato_i (vibrato_i),
    .vib_shift (vib_shift),
`ifdef TONE_OSC_DUTY_EN
    .duty      (duty),
`endif
    .wave_o    (wave_o),
    .cycle_o   (cycle_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    exp_q.delete();
  endtask

  // Queue one waveform period measured in clocks: high_clk clocks high, then low.
  task automatic push_period(input int total_clk, input int high_clk, input bit strobe);
    for (int i = 0; i < total_clk; i++)
      exp_q.push_back({(i < high_clk) ? 1'b1 : 1'b0, (strobe && i == 0) ? 1'b1 : 1'b0});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; period = 12'd4; vibrato_i = 4'd0; vib_shift = 2'd0; duty = 8'd127;
    for (int i = 0; i < 4; i++) exp_q.push_back(2'b00);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({wave_o, cycle_o} !== exp_v) begin
        n_err++;
        $display("FAIL reset: got %b want %b", {wave_o, cycle_o}, exp_v);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    enable = 1'b1; period = 12'd4; vibrato_i = 4'd0; vib_shift = 2'd0;
    rst_n = 1'b1;
    exp_q.push_back(2'b00);
    push_period(8, 4, 1'b0);
    push_period(8, 4, 1'b1);
    push_period(8, 4, 1'b1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({wave_o, cycle_o} !== exp_v) begin
        n_err++;
        $display("FAIL basic: got %b want %b (left %0d)", {wave_o, cycle_o}, exp_v, exp_q.size());
      end
    end
  endtask

  task automatic test_vibrato();
    int k;
    do_reset();
    enable = 1'b1; period = 12'd100; vibrato_i = 4'd5; vib_shift = 2'd2;
    rst_n = 1'b1;
    exp_q.push_back(2'b00);
    push_period(240, 120, 1'b0);
    push_period(200, 100, 1'b1);
    exp_q.push_back(2'b11);
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({wave_o, cycle_o} !== exp_v) begin
        n_err++;
        $display("FAIL vibrato: got %b want %b at clk %0d", {wave_o, cycle_o}, exp_v, k);
      end
      if (k == 100) vibrato_i = 4'd0;
      k++;
    end
  endtask

  task automatic test_saturation();
    int k;
    do_reset();
    enable = 1'b1; period = 12'd4094; vibrato_i = 4'd15; vib_shift = 2'd3;
    rst_n = 1'b1;
    exp_q.push_back(2'b00);
    push_period(2 * 4095, 2 * 2048, 1'b0);
    exp_q.push_back(2'b11);
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({wave_o, cycle_o} !== exp_v) begin
        n_err++;
        $display("FAIL saturation: got %b want %b at clk %0d", {wave_o, cycle_o}, exp_v, k);
      end
      k++;
    end
  endtask

  task automatic test_mute();
    int k;
    do_reset();
    enable = 1'b1; period = 12'd10; vibrato_i = 4'd0; vib_shift = 2'd0;
    rst_n = 1'b1;
    exp_q.push_back(2'b00);
    push_period(20, 10, 1'b0);
    exp_q.push_back(2'b01);
    for (int i = 0; i < 11; i++) exp_q.push_back(2'b00);
    push_period(20, 10, 1'b0);
    exp_q.push_back(2'b11);
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({wave_o, cycle_o} !== exp_v) begin
        n_err++;
        $display("FAIL mute: got %b want %b at clk %0d", {wave_o, cycle_o}, exp_v, k);
      end
      if (k == 5)  period = 12'd0;
      if (k == 31) period = 12'd10;
      k++;
    end
  endtask

  task automatic test_interrupt(input bit use_rst);
    int k;
    do_reset();
    enable = 1'b1; period = 12'd4; vibrato_i = 4'd0; vib_shift = 2'd0;
    rst_n = 1'b1;
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    push_period(8, 4, 1'b0);
    exp_q.push_back(2'b11);
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({wave_o, cycle_o} !== exp_v) begin
        n_err++;
        $display("FAIL interrupt(rst=%0d): got %b want %b at clk %0d", use_rst, {wave_o, cycle_o}, exp_v, k);
      end
      if (k == 2) begin
        if (use_rst) rst_n = 1'b0; else enable = 1'b0;
      end
      if (k == 3) begin
        rst_n  = 1'b1;
        enable = 1'b1;
      end
      k++;
    end
  endtask

  task automatic test_period_one();
    do_reset();
    enable = 1'b1; period = 12'd1; vibrato_i = 4'd0; vib_shift = 2'd0;
    rst_n = 1'b1;
    exp_q.push_back(2'b00);
    push_period(2, 2, 1'b0);
    push_period(2, 2, 1'b1);
    push_period(2, 2, 1'b1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({wave_o, cycle_o} !== exp_v) begin
        n_err++;
        $display("FAIL period_one: got %b want %b", {wave_o, cycle_o}, exp_v);
      end
    end
  endtask

`ifdef TONE_OSC_DUTY_EN
  task automatic test_duty();
    logic [7:0] duty_tab[3];
    int         high_tab[3];
    duty_tab[0] = 8'd63;  high_tab[0] = 8;
    duty_tab[1] = 8'd255; high_tab[1] = 32;
    duty_tab[2] = 8'd0;   high_tab[2] = 0;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      enable = 1'b1; period = 12'd16; vibrato_i = 4'd0; vib_shift = 2'd0; duty = duty_tab[t];
      rst_n = 1'b1;
      exp_q.push_back(2'b00);
      push_period(32, high_tab[t], 1'b0);
      push_period(32, high_tab[t], 1'b1);
      push_period(32, high_tab[t], 1'b1);
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if ({wave_o, cycle_o} !== exp_v) begin
          n_err++;
          $display("FAIL duty(%0d): got %b want %b", duty_tab[t], {wave_o, cycle_o}, exp_v);
        end
      end
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_vibrato();
    test_saturation();
    test_mute();
    test_interrupt(1'b0);
    test_interrupt(1'b1);
    test_period_one();
`ifdef TONE_OSC_DUTY_EN
    test_duty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
